// File: rtl/ladybird_config.sv
// ladybird_config: shared configuration for the ladybird core.
//   XLEN        - architectural register width
//   csr_state_e - CSR stage sequencing states
package ladybird_config;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        CSR_ST_IDLE   = 2'd0,
        CSR_ST_ACCESS = 2'd1,
        CSR_ST_WB     = 2'd2
    } csr_state_e;

endpackage

// File: rtl/ladybird_riscv_helper.sv
// ladybird_riscv_helper: RISC-V encoding constants and small decode helpers
// shared by the ladybird pipeline stages.
package ladybird_riscv_helper;

    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [2:0] FUNCT3_CSRRW  = 3'b001;
    localparam logic [2:0] FUNCT3_CSRRS  = 3'b010;
    localparam logic [2:0] FUNCT3_CSRRC  = 3'b011;
    localparam logic [2:0] FUNCT3_CSRRWI = 3'b101;
    localparam logic [2:0] FUNCT3_CSRRSI = 3'b110;
    localparam logic [2:0] FUNCT3_CSRRCI = 3'b111;

    // Set/clear forms with a zero rs1/zimm field are pure reads.
    function automatic logic csr_write_intent(input logic [2:0] funct3,
                                              input logic [4:0] rs1_field);
        logic w;
        case (funct3)
            FUNCT3_CSRRW, FUNCT3_CSRRWI:                 w = 1'b1;
            FUNCT3_CSRRS, FUNCT3_CSRRC,
            FUNCT3_CSRRSI, FUNCT3_CSRRCI:                w = (rs1_field != 5'd0);
            default:                                     w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic csr_funct3_valid(input logic [2:0] funct3);
        return (funct3[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ladybird_csr_stage.sv
// ladybird_csr_stage: executes one Zicsr instruction per pass through
// IDLE -> ACCESS -> WB, driving a combinational CSR file during ACCESS.
// Ports:
//   clk, nrst                      clock, async active-low reset
//   req_valid/req_ready            instruction handshake (inst, pc, rs1 value)
//   csr_op/valid/addr/wdata/rdata  CSR file access; valid is the write strobe
//   wb_valid/ready, wb_rd/data     register writeback handshake
//   wb_illegal                     instruction trapped as illegal
//   retire, retire_inst/pc/next_pc one-cycle retirement pulse for legal insts
module ladybird_csr_stage
    import ladybird_config::*;
    import ladybird_riscv_helper::*;
#(
    parameter bit TRAP_RO_WRITE = 1'b1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_inst,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_rs1_data,
    output logic [2:0]      csr_op,
    output logic            csr_valid,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_illegal,
    output logic            retire,
    output logic [31:0]     retire_inst,
    output logic [XLEN-1:0] retire_pc,
    output logic [XLEN-1:0] retire_next_pc
);

    csr_state_e      r_state;
    csr_state_e      w_state_next;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_wb_data;
    logic            r_illegal;

    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1_field;
    logic [11:0]     w_addr;
    logic            w_write;
    logic            w_illegal;

    // Decode always works from the latched instruction, so the CSR-facing
    // fields naturally hold their values outside ACCESS.
    assign w_funct3    = r_inst[14:12];
    assign w_rs1_field = r_inst[19:15];
    assign w_addr      = r_inst[31:20];
    assign w_write     = csr_write_intent(w_funct3, w_rs1_field);
    assign w_illegal   = !csr_funct3_valid(w_funct3)
                       || (r_inst[6:0] != OPCODE_SYSTEM)
                       || (TRAP_RO_WRITE && w_write && (w_addr[11:10] == 2'b11));

    assign csr_addr  = w_addr;
    assign csr_op    = w_funct3;
    assign csr_wdata = w_funct3[2] ? {{(XLEN-5){1'b0}}, w_rs1_field} : r_rs1;

    assign wb_rd          = r_inst[11:7];
    assign wb_data        = r_wb_data;
    assign retire_inst    = r_inst;
    assign retire_pc      = r_pc;
    assign retire_next_pc = r_pc + XLEN'(4);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= CSR_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        csr_valid    = 1'b0;
        wb_valid     = 1'b0;
        wb_illegal   = 1'b0;
        retire       = 1'b0;
        case (r_state)
            CSR_ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = CSR_ST_ACCESS;
                end
            end
            CSR_ST_ACCESS: begin
                csr_valid    = w_write && !w_illegal;
                w_state_next = CSR_ST_WB;
            end
            CSR_ST_WB: begin
                wb_valid   = 1'b1;
                wb_illegal = r_illegal;
                if (wb_ready) begin
                    retire       = !r_illegal;
                    w_state_next = CSR_ST_IDLE;
                end
            end
            default: begin
                w_state_next = CSR_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_inst    <= '0;
            r_pc      <= '0;
            r_rs1     <= '0;
            r_wb_data <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == CSR_ST_IDLE && req_valid) begin
                r_inst <= req_inst;
                r_pc   <= req_pc;
                r_rs1  <= req_rs1_data;
            end
            if (r_state == CSR_ST_ACCESS) begin
                r_wb_data <= w_illegal ? '0 : csr_rdata;
                r_illegal <= w_illegal;
            end
        end
    end

endmodule

// File: doc/ladybird_csr_stage.md
LADYBIRD_CSR_STAGE -- requirements
Module: ladybird_csr_stage

Interface
REQ-001 SHALL have parameter TRAP_RO_WRITE, default 1, meaning a write attempt to a read-only CSR (addr[11:10]==2'b11) is reported as illegal.
REQ-002 SHALL have ports clk  input  1  clock; nrst  input  1  reset; reset is asynchronous and active-low.
REQ-003 SHALL have ports req_valid  input  1  CSR instruction offered; req_ready  output  1  stage can accept.
REQ-004 SHALL have ports req_inst  input  32  instruction word; req_pc  input  XLEN  instruction PC; req_rs1_data  input  XLEN  rs1 register value.
REQ-005 SHALL have ports csr_op  output  3  funct3 to CSR file; csr_valid  output  1  write strobe; csr_addr  output  12  CSR address; csr_wdata  output  XLEN  operand; csr_rdata  input  XLEN  combinational read data.
REQ-006 SHALL have ports wb_valid  output  1; wb_ready  input  1; wb_rd  output  5; wb_data  output  XLEN; wb_illegal  output  1.
REQ-007 SHALL have ports retire  output  1; retire_inst  output  32; retire_pc  output  XLEN; retire_next_pc  output  XLEN.

Function
REQ-008 SHALL implement a three-state FSM: IDLE, ACCESS, WB.
REQ-009 In IDLE, req_ready=1; req_valid&req_ready SHALL latch inst, pc and rs1_data and move to ACCESS; req_ready=0 in ACCESS and WB.
REQ-010 In ACCESS (exactly one cycle), csr_addr=inst[31:20], csr_op=inst[14:12], csr_wdata=rs1_data for funct3[2]==0, else zero-extended zimm inst[19:15]; csr_rdata SHALL be registered into wb_data at the end of ACCESS; next state WB.
REQ-011 csr_valid SHALL be 1 only in ACCESS, only for a legal instruction with write intent: CSRRW/CSRRWI always; CSRRS/CSRRC/CSRRSI/CSRRCI only when inst[19:15]!=0.
REQ-012 Illegal SHALL be: funct3 of 000 or 100, or opcode!=7'b1110011, or (TRAP_RO_WRITE and write intent and addr[11:10]==2'b11); illegal SHALL suppress csr_valid and set wb_illegal.
REQ-013 In WB, wb_valid=1 and wb_rd, wb_data and wb_illegal SHALL stay stable until wb_ready; when illegal, wb_data=0.
REQ-014 On the cycle wb_valid&wb_ready, retire SHALL pulse for one cycle (legal only), with retire_inst=inst, retire_pc=pc, retire_next_pc=pc+4 (mod 2^XLEN); the FSM returns to IDLE.
REQ-015 Minimum latency SHALL be accept at cycle N, csr_valid at N+1, wb_valid at N+2; throughput SHALL be one instruction per 3 cycles with wb_ready held high.
REQ-016 wb_rd=0 SHALL still complete the handshake; suppression of the x0 write is left to the register file.
REQ-017 Outside ACCESS, csr_addr, csr_op and csr_wdata SHALL hold their latched values, and csr_valid=0.

Reset
REQ-018 Asserting nrst low at any time SHALL immediately force IDLE, req_ready=1 after release, csr_valid=0, wb_valid=0, wb_illegal=0, retire=0; all data registers SHALL reset to 0.
REQ-019 Reset during ACCESS or WB SHALL abandon the instruction, with no retire and no later csr_valid.

Structure
REQ-020 The FSM state enum, OPCODE_SYSTEM and FUNCT3_CSR* constants SHALL live in the shared ladybird_config/ladybird_riscv_helper packages; XLEN SHALL come from ladybird_config.
REQ-021 The block SHALL be flat, with no sub-module; it instantiates alongside ladybird_csr and connects csr_* to i_op/i_valid/i_addr/i_data/o_data.

Verification
REQ-022 csrrw x5,0x305,x6 with rs1=0x80000100 and csr_rdata=0x0 -> csr_valid=1 in ACCESS, csr_wdata=0x80000100, wb_rd=5, wb_data=0x0, then a retire pulse with retire_next_pc=pc+4.
REQ-023 csrrs x7,0xC00,x0 -> csr_valid stays 0, wb_data=csr_rdata sampled in ACCESS, wb_illegal=0, retire=1.
REQ-024 csrrwi x1,0xC00,5 -> wb_illegal=1, csr_valid=0, wb_data=0, no retire; with TRAP_RO_WRITE=0 -> csr_valid=1 and legal completion.
REQ-025 wb_ready held low for 4 cycles in WB -> wb_* stable, req_ready=0, retire only on the handshake cycle; back-to-back requests accepted every 3 cycles when wb_ready=1.
REQ-026 nrst pulsed low during ACCESS -> csr_valid drops asynchronously, no wb_valid and no retire; the next request is processed normally.
REQ-027 funct3=100 with SYSTEM opcode, and pc=0xFFFFFFFC legal csrrc with zimm=0 -> the first gives illegal; the second gives no write and retire_next_pc=0x00000000.
